// File: rtl/museq_pkg.sv
// museq_pkg: shared encodings for the micro-sequencer (ns_ctl codes, condition selects, 4:1 mux selects, state width)
package museq_pkg;
  localparam int STATE_W = 6;
  localparam logic [2:0] NS_DECODE = 3'b000;
  localparam logic [2:0] NS_INC    = 3'b001;
  localparam logic [2:0] NS_JUMP   = 3'b010;
  localparam logic [2:0] NS_CBR    = 3'b011;
  localparam logic [2:0] NS_WAIT   = 3'b100;
  localparam logic [2:0] NS_FETCH  = 3'b101;
  localparam logic [2:0] NS_CALL   = 3'b110;
  localparam logic [2:0] NS_RET    = 3'b111;
  localparam logic [1:0] COND_MOC  = 2'd0;
  localparam logic [1:0] COND_PASS = 2'd1;
  localparam logic [1:0] COND_Z    = 2'd2;
  localparam logic [1:0] COND_N    = 2'd3;
  localparam logic [1:0] SEL_ENC   = 2'b00;
  localparam logic [1:0] SEL_INC   = 2'b01;
  localparam logic [1:0] SEL_CR    = 2'b10;
  localparam logic [1:0] SEL_D3    = 2'b11;
endpackage

// File: rtl/museq_cond_eval.sv
// museq_cond_eval: selects one condition source and optionally inverts it; ports cond_in[3:0], cond_sel, cond_inv, cond (out)
module museq_cond_eval (
  input  logic [3:0] cond_in,
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  output logic       cond
);
  always_comb cond = cond_in[cond_sel] ^ cond_inv;
endmodule

// File: rtl/mux_2to1_6bits.sv
// mux_2to1_6bits: 6-bit 2:1 mux; ports d0, d1 (data), sel, y (out)
module mux_2to1_6bits (
  input  logic [5:0] d0,
  input  logic [5:0] d1,
  input  logic       sel,
  output logic [5:0] y
);
  always_comb y = sel ? d1 : d0;
endmodule

// File: rtl/mux_4to1_6bits.sv
// mux_4to1_6bits: 6-bit 4:1 mux; ports d0..d3 (data), sel (2b), y (out)
module mux_4to1_6bits (
  input  logic [5:0] d0,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [1:0] sel,
  output logic [5:0] y
);
  always_comb y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram next-state controller with wait timeout.
// Ports: clk, reset_n (async active-low), ns_ctl, cr_addr, enc_addr, cond_in, cond_sel,
// cond_inv, stall -> state, mux4_sel, mux2_sel, fault (one-cycle timeout pulse).
// Define MUSEQ_CALL_EN to add single-level CALL/RET through a return register.
module micro_sequencer
  import museq_pkg::*;
#(
  parameter int          AW          = STATE_W,
  parameter logic [AW-1:0] RESET_STATE = 6'd0,
  parameter logic [AW-1:0] FETCH_STATE = 6'd1,
  parameter logic [AW-1:0] FAULT_STATE = 6'd63,
  parameter int          MAX_WAIT    = 15,
  parameter int          CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    ns_ctl,
  input  logic [AW-1:0] cr_addr,
  input  logic [AW-1:0] enc_addr,
  input  logic [3:0]    cond_in,
  input  logic [1:0]    cond_sel,
  input  logic          cond_inv,
  input  logic          stall,
  output logic [AW-1:0] state,
  output logic [1:0]    mux4_sel,
  output logic          mux2_sel,
  output logic          fault
);
  logic [AW-1:0] state_q, state_d, inc_addr, d3_addr, mux4_y, mux2_y;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic fault_q, fault_d, cond, hold, timeout;

  museq_cond_eval u_cond (.cond_in(cond_in), .cond_sel(cond_sel), .cond_inv(cond_inv), .cond(cond));

  assign inc_addr = state_q + 1'b1;

`ifdef MUSEQ_CALL_EN
  logic [AW-1:0] ret_q, ret_d;
  always_comb begin
    d3_addr = (ns_ctl == NS_RET) ? ret_q : FETCH_STATE;
    ret_d   = (!stall && ns_ctl == NS_CALL) ? inc_addr : ret_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ret_q <= RESET_STATE;
    else          ret_q <= ret_d;
`else
  assign d3_addr = FETCH_STATE;
`endif

  always_comb begin
    hold     = (ns_ctl == NS_WAIT) && !cond;
    mux2_sel = hold;
    mux4_sel = (ns_ctl == NS_DECODE) ? SEL_ENC :
               (ns_ctl == NS_JUMP)   ? SEL_CR  :
               (ns_ctl == NS_CBR)    ? (cond ? SEL_CR : SEL_INC) :
               (ns_ctl == NS_FETCH)  ? SEL_D3  :
`ifdef MUSEQ_CALL_EN
               (ns_ctl == NS_CALL)   ? SEL_CR  :
               (ns_ctl == NS_RET)    ? SEL_D3  :
`endif
               SEL_INC;
  end

  mux_4to1_6bits u_mux4 (.d0(enc_addr), .d1(inc_addr), .d2(cr_addr), .d3(d3_addr), .sel(mux4_sel), .y(mux4_y));
  mux_2to1_6bits u_mux2 (.d0(mux4_y), .d1(state_q), .sel(mux2_sel), .y(mux2_y));

  // Timeout overrides the hold path; a true condition already cleared hold, so cond wins.
  always_comb begin
    timeout    = hold && (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
    state_d    = stall ? state_q : timeout ? FAULT_STATE : mux2_y;
    wait_cnt_d = stall ? wait_cnt_q : (hold && !timeout) ? wait_cnt_q + 1'b1 : '0;
    fault_d    = !stall && timeout;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end

  assign state = state_q;
  assign fault = fault_q;

  ns_ctl_known: assert property (@(posedge clk) disable iff (!reset_n) !$isunknown(ns_ctl));
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram next-state controller for the control unit.
- Holds the 6-bit current control-state register and evaluates the microinstruction's next-state control and condition fields.
- Drives the selects of the 6-bit 4:1 next-address mux and the 2:1 hold mux.
- Adds a bounded wait-for-memory timeout that forces a fault state.

Parameters:
- AW, 6, state/address width; must match the 6-bit muxes.
- RESET_STATE, 6'd0, state loaded on reset.
- FETCH_STATE, 6'd1, instruction-fetch entry state.
- FAULT_STATE, 6'd63, state forced on wait timeout.
- MAX_WAIT, 15, maximum hold cycles in a WAIT before fault; range 1..2^CNT_W-1.
- CNT_W, 4, wait counter width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ns_ctl  in  3  next-state control field of the current microinstruction
- cr_addr  in  AW  branch-target field of the current microinstruction
- enc_addr  in  AW  decode (instruction encoder) address
- cond_in  in  4  condition sources: [0] MOC, [1] cond_pass, [2] Z, [3] N
- cond_sel  in  2  selects cond_in bit
- cond_inv  in  1  inverts the selected condition
- stall  in  1  freeze: state and counter hold, fault is not asserted
- state  out  AW  current control state (microstore address)
- mux4_sel  out  2  select of the 4:1 mux: 00 enc_addr, 01 state+1, 10 cr_addr, 11 FETCH_STATE
- mux2_sel  out  1  select of the 2:1 mux: 0 uses the 4:1 output, 1 holds state
- fault  out  1  one-cycle pulse on wait timeout

Behaviour:
- Reset (asynchronous, any time, including mid-WAIT):
  - state=RESET_STATE, wait_cnt=0, fault=0.
  - mux selects are evaluated combinationally from the inputs; with ns_ctl=000 they are 00/0.
- cond = cond_in[cond_sel] XOR cond_inv. Purely combinational.
- ns_ctl decode gives mux4_sel/mux2_sel, combinational, same cycle:
  - 000 DECODE: 00/0
  - 001 INC: 01/0
  - 010 JUMP: 10/0
  - 011 CBR: cond ? 10/0 : 01/0
  - 100 WAIT: cond ? 01/0 : xx/1 (hold); xx is driven as 01
  - 101 FETCH: 11/0
  - 110, 111: see Optional Feature
- On each rising edge with stall=0, state <= the 2:1 mux output. There is one-cycle latency from microinstruction fields to the new state.
- The incrementer is state+1 mod 2^AW, so 63 wraps to 0. No carry or flag is produced.
- Wait counter:
  - Increments on each non-stalled edge where ns_ctl=WAIT and cond=0.
  - Clears to 0 on any non-stalled edge where the WAIT is not held.
  - When ns_ctl=WAIT, cond=0 and wait_cnt==MAX_WAIT-1, the next edge loads FAULT_STATE (overriding the hold), clears wait_cnt and registers fault=1 for exactly one cycle.
- Simultaneous cond=1 on the timeout cycle: cond wins, so state+1 is loaded and no fault occurs.
- stall=1: state, wait_cnt and return register hold; fault deasserts next edge; mux selects still reflect the inputs.
- Illegal or unknown inputs are not checked; X on ns_ctl is a verification error, enforced by assertion.

Optional Feature:
- Macro MUSEQ_CALL_EN.
- When defined:
  - Adds an AW-bit return register, reset to RESET_STATE.
  - 110 CALL: next=cr_addr (sel 10/0); ret <= state+1 on the same edge.
  - 111 RET: next=ret.
  - The 4:1 D3 input is widened to a local mux (FETCH_STATE when ns_ctl=101, ret when ns_ctl=111), so mux4_sel=11 for both.
  - The register is single-level; a nested CALL overwrites it.
- When undefined: 110 and 111 behave exactly as INC (01/0) and no return register exists.

Decomposition:
- Package museq_pkg:
  - ns_ctl encodings (NS_DECODE..NS_RET)
  - cond_sel encodings (COND_MOC, COND_PASS, COND_Z, COND_N)
  - mux select constants
  - state width localparam
- The datapath instantiates the existing mux_4to1_6bits and mux_2to1_6bits for next-address selection.
- One natural sub-module: museq_cond_eval, combinational condition select/invert.
- Counter and state register stay in the top.

Test Plan:
- Reset: reset_n=0 mid-WAIT with wait_cnt=7 -> state=0, fault=0 immediately; after release with ns_ctl=001, state=1 after one edge.
- Sequencing:
  - state=5, ns_ctl=001 -> state=6.
  - ns_ctl=010, cr_addr=40 -> state=40.
  - state=63, INC -> state=0 (wrap).
  - ns_ctl=101 -> state=1.
  - ns_ctl=000, enc_addr=22 -> state=22.
- Conditional branch: state=10, ns_ctl=011, cond_sel=Z, cond_in=0100, cond_inv=0 -> state=40 (cr_addr=40); with cond_inv=1 -> state=11.
- Wait: state=12, ns_ctl=100, cond_sel=MOC:
  - MOC low 3 cycles then high -> state holds 12 for 3 edges, mux2_sel=1, then state=13, wait_cnt=0.
  - MOC never high -> after 15 edges state=63, fault high exactly one cycle.
  - MOC rising on the 15th cycle -> state=13, no fault.
- Stall: stall=1 for 4 cycles during WAIT with MOC low -> state and wait_cnt frozen, no fault; the timeout still occurs after 15 non-stalled cycles.
- MUSEQ_CALL_EN:
  - state=20, CALL cr_addr=50 -> state=50; later RET -> state=21.
  - With the macro undefined, ns_ctl=110 at state=20 -> state=21.
